// File: rtl/wave_pkg.sv
// Shared geometry, state encoding and row mapping for the waveform capture/render block.
package wave_pkg;

  localparam int DATA_W       = 8;
  localparam int DEPTH        = 512;
  localparam int H_START      = 64;
  localparam int V_START      = 112;
  localparam int V_SWAP       = 480;
  localparam int AUTO_TIMEOUT = 4096;
  localparam int ADDR_W       = $clog2(DEPTH);
  localparam int TMO_W        = $clog2(AUTO_TIMEOUT);

  typedef enum logic [1:0] {
    ARM,
    WAIT_TRIG,
    CAPTURE,
    DONE
  } state_t;

  // Larger samples sit higher on screen: full scale lands on V_START.
  function automatic logic [9:0] y_of(input logic [DATA_W-1:0] s);
    return 10'(V_START + (1 << DATA_W) - 1) - 10'(s);
  endfunction

endpackage

// File: rtl/wave_buf_ram.sv
// Two-bank sample store: one write port, one registered read port, single clock.
module wave_buf_ram
  import wave_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W:0]   raddr,
  output logic [DATA_W-1:0] rq
);

  logic [DATA_W-1:0] mem [2*DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rq <= mem[raddr];
  end

endmodule

// File: rtl/wave_capture_render.sv
// Triggered capture into a ping-pong buffer and per-pixel trace rasterisation.
// The displayed bank flips only at the vertical-blank swap point.
module wave_capture_render
  import wave_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [7:0]        decim,
  input  logic [9:0]        cnt_h,
  input  logic [9:0]        cnt_v,
  output logic              vga_wave,
  output logic              capture_busy,
  output logic              trig_auto,
  output logic              frame_swap
);

  state_t              state_reg, state_next;
  logic [7:0]          dec_cnt_reg;
  logic [ADDR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [TMO_W-1:0]    tmo_reg, tmo_next;
  logic [DATA_W-1:0]   prev_sample_reg, prev_sample_next;
  logic                auto_pending_reg, auto_pending_next;
  logic                disp_bank_reg, disp_valid_reg, trig_auto_reg;
  logic [DATA_W-1:0]   prev_col_reg;

  logic                accept, swap_pt, trig_hit, we, rd_en;
  logic [ADDR_W:0]     waddr, raddr;
  logic [DATA_W-1:0]   rd_q;

  assign accept   = sample_en && (dec_cnt_reg == decim);
  assign swap_pt  = (cnt_h == 10'd0) && (cnt_v == 10'(V_SWAP));
  assign trig_hit = (prev_sample_reg < trig_level) && (sample_data >= trig_level);

  always_comb begin
    state_next        = state_reg;
    wr_ptr_next       = wr_ptr_reg;
    tmo_next          = tmo_reg;
    prev_sample_next  = prev_sample_reg;
    auto_pending_next = auto_pending_reg;
    we                = 1'b0;
    waddr             = {~disp_bank_reg, wr_ptr_reg};
    case (state_reg)
      ARM: begin
        if (accept) begin
          prev_sample_next = sample_data;
          tmo_next         = '0;
          state_next       = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        if (accept) begin
          prev_sample_next = sample_data;
          if (trig_hit || (tmo_reg == TMO_W'(AUTO_TIMEOUT - 1))) begin
            we                = 1'b1;
            waddr             = {~disp_bank_reg, {ADDR_W{1'b0}}};
            wr_ptr_next       = ADDR_W'(1);
            auto_pending_next = !trig_hit;
            state_next        = CAPTURE;
          end else begin
            tmo_next = tmo_reg + 1'b1;
          end
        end
      end
      CAPTURE: begin
        if (accept) begin
          we          = 1'b1;
          wr_ptr_next = wr_ptr_reg + 1'b1;
          if (wr_ptr_reg == ADDR_W'(DEPTH - 1)) state_next = DONE;
        end
      end
      DONE: begin
        if (swap_pt) state_next = ARM;
      end
      default: state_next = ARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ARM;
      dec_cnt_reg      <= '0;
      wr_ptr_reg       <= '0;
      tmo_reg          <= '0;
      prev_sample_reg  <= '0;
      auto_pending_reg <= 1'b0;
      disp_bank_reg    <= 1'b0;
      disp_valid_reg   <= 1'b0;
      trig_auto_reg    <= 1'b0;
      prev_col_reg     <= '0;
    end else begin
      state_reg        <= state_next;
      wr_ptr_reg       <= wr_ptr_next;
      tmo_reg          <= tmo_next;
      prev_sample_reg  <= prev_sample_next;
      auto_pending_reg <= auto_pending_next;
      prev_col_reg     <= rd_q;
      if (sample_en) dec_cnt_reg <= accept ? 8'd0 : dec_cnt_reg + 8'd1;
      if (state_reg == DONE && swap_pt) begin
        disp_bank_reg  <= ~disp_bank_reg;
        disp_valid_reg <= 1'b1;
        trig_auto_reg  <= auto_pending_reg;
      end
    end
  end

  // Read one column ahead so rd_q holds the current column's sample.
  assign rd_en = (cnt_h >= 10'(H_START - 1)) && (cnt_h <= 10'(H_START + DEPTH - 2));
  assign raddr = {disp_bank_reg, ADDR_W'(cnt_h - 10'(H_START - 1))};

  wave_buf_ram u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (sample_data),
    .re    (rd_en),
    .raddr (raddr),
    .rq    (rd_q)
  );

  logic       in_plot;
  logic [9:0] y_cur, y_prev, y_lo, y_hi;

  always_comb begin
    in_plot = (cnt_h >= 10'(H_START)) && (cnt_h < 10'(H_START + DEPTH));
    y_cur   = y_of(rd_q);
    y_prev  = (cnt_h == 10'(H_START)) ? y_cur : y_of(prev_col_reg);
    y_lo    = (y_cur < y_prev) ? y_cur : y_prev;
    y_hi    = (y_cur < y_prev) ? y_prev : y_cur;
  end

  assign vga_wave     = disp_valid_reg && in_plot && (cnt_v >= y_lo) && (cnt_v <= y_hi);
  assign capture_busy = (state_reg != DONE);
  assign trig_auto    = trig_auto_reg;
  assign frame_swap   = (state_reg == DONE) && swap_pt;

endmodule

// File: tb/tb_wave_capture_render.sv
// Directed bench for wave_capture_render: capture, trigger, swap timing and rendered pixels.
module tb_wave_capture_render;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_en;
  logic [7:0] sample_data;
  logic [7:0] trig_level;
  logic [7:0] decim;
  logic [9:0] cnt_h;
  logic [9:0] cnt_v;
  logic       vga_wave;
  logic       capture_busy;
  logic       trig_auto;
  logic       frame_swap;

  int n_vec = 0;
  int n_err = 0;
  int cnt;

  always #5 clk = ~clk;

  wave_capture_render dut (
    .clk          (clk),
    .rst          (rst),
    .sample_en    (sample_en),
    .sample_data  (sample_data),
    .trig_level   (trig_level),
    .decim        (decim),
    .cnt_h        (cnt_h),
    .cnt_v        (cnt_v),
    .vga_wave     (vga_wave),
    .capture_busy (capture_busy),
    .trig_auto    (trig_auto),
    .frame_swap   (frame_swap)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Walk two columns up to (h, v) so the read pipeline and prev-column register are primed.
  task automatic px(input string tag, input int h, input int v, input logic exp);
    cnt_v = 10'(v);
    cnt_h = 10'(h - 2);
    step();
    cnt_h = 10'(h - 1);
    step();
    cnt_h = 10'(h);
    #1;
    chk(tag, {31'd0, vga_wave}, {31'd0, exp});
  endtask

  // mode 0: ramp (start+i)%256, mode 1: constant start. Stops once capture reaches DONE.
  task automatic feed(input string tag, input int mode, input int start, input int bound,
                      output int n);
    n = 0;
    cnt_h = 10'd10;
    cnt_v = 10'd0;
    for (int i = 0; i < bound; i++) begin
      sample_en   = 1'b1;
      sample_data = (mode == 0) ? 8'((start + i) % 256) : 8'(start);
      step();
      n = i + 1;
      if (!capture_busy) break;
    end
    sample_en = 1'b0;
    chk({tag, "_done"}, {31'd0, capture_busy}, 32'd0);
  endtask

  task automatic do_swap(input string tag);
    cnt_h = 10'd0;
    cnt_v = 10'd480;
    #1;
    chk({tag, "_pulse"}, {31'd0, frame_swap}, 32'd1);
    step();
    chk({tag, "_pulse_end"}, {31'd0, frame_swap}, 32'd0);
    chk({tag, "_rearm"}, {31'd0, capture_busy}, 32'd1);
    cnt_h = 10'd10;
    cnt_v = 10'd0;
  endtask

  initial begin
    rst = 1'b1; sample_en = 1'b0; sample_data = 8'd0;
    trig_level = 8'd128; decim = 8'd0; cnt_h = 10'd64; cnt_v = 10'd239;

    // Reset state
    repeat (3) step();
    chk("rst_busy", {31'd0, capture_busy}, 32'd1);
    chk("rst_wave", {31'd0, vga_wave}, 32'd0);
    chk("rst_swap", {31'd0, frame_swap}, 32'd0);
    chk("rst_auto", {31'd0, trig_auto}, 32'd0);
    rst = 1'b0;
    step();
    begin
      int hs[5] = '{63, 64, 65, 300, 575};
      int vs[3] = '{112, 239, 367};
      foreach (hs[a]) foreach (vs[b]) px("blank", hs[a], vs[b], 1'b0);
    end
    chk("blank_busy", {31'd0, capture_busy}, 32'd1);

    // Ramp, level 128: trigger on 127->128, done after 640 strobes
    feed("ramp", 0, 0, 2000, cnt);
    chk("ramp_count", 32'(cnt), 32'd640);
    cnt_h = 10'd0; cnt_v = 10'd200;
    repeat (3) step();
    chk("ramp_midframe_swap", {31'd0, frame_swap}, 32'd0);
    chk("ramp_midframe_busy", {31'd0, capture_busy}, 32'd0);
    px("ramp_not_shown", 64, 239, 1'b0);
    do_swap("ramp_swap");
    chk("ramp_auto", {31'd0, trig_auto}, 32'd0);
    px("ramp_c0_239", 64, 239, 1'b1);
    px("ramp_c0_238", 64, 238, 1'b0);
    px("ramp_c0_240", 64, 240, 1'b0);
    px("ramp_c1_238", 65, 238, 1'b1);
    px("ramp_c1_239", 65, 239, 1'b1);
    px("ramp_c1_237", 65, 237, 1'b0);
    px("ramp_c1_240", 65, 240, 1'b0);
    px("ramp_c127_112", 191, 112, 1'b1);
    px("ramp_c128_250", 192, 250, 1'b1);
    px("ramp_c128_367", 192, 367, 1'b1);
    px("ramp_c128_368", 192, 368, 1'b0);
    px("ramp_c511_240", 575, 240, 1'b1);
    px("ramp_c511_241", 575, 241, 1'b1);
    px("ramp_right_edge", 576, 240, 1'b0);
    px("ramp_left_edge", 63, 239, 1'b0);

    // Decimation by 4: accepted values are multiples of 4, trigger on 124->128
    decim = 8'd3;
    feed("decim", 0, 1, 4000, cnt);
    chk("decim_count", 32'(cnt), 32'd2172);
    cnt_h = 10'd0; cnt_v = 10'd200;
    repeat (3) step();
    chk("decim_midframe_swap", {31'd0, frame_swap}, 32'd0);
    px("decim_old_c1_238", 65, 238, 1'b1);
    px("decim_old_c1_235", 65, 235, 1'b0);
    chk("decim_still_done", {31'd0, capture_busy}, 32'd0);
    do_swap("decim_swap");
    chk("decim_auto", {31'd0, trig_auto}, 32'd0);
    px("decim_c0_239", 64, 239, 1'b1);
    px("decim_c1_235", 65, 235, 1'b1);
    px("decim_c1_237", 65, 237, 1'b1);
    px("decim_c1_239", 65, 239, 1'b1);
    px("decim_c1_234", 65, 234, 1'b0);
    px("decim_c1_240", 65, 240, 1'b0);
    px("decim_c2_231", 66, 231, 1'b1);
    px("decim_c2_236", 66, 236, 1'b0);

    // Constant 200 never crosses level 100: auto-trigger
    decim = 8'd0;
    trig_level = 8'd100;
    feed("auto", 1, 200, 6000, cnt);
    chk("auto_count", {31'd0, (cnt >= 4600 && cnt <= 4610)}, 32'd1);
    do_swap("auto_swap");
    chk("auto_flag", {31'd0, trig_auto}, 32'd1);
    px("auto_c0_167", 64, 167, 1'b1);
    px("auto_c0_166", 64, 166, 1'b0);
    px("auto_c0_168", 64, 168, 1'b0);
    px("auto_mid_167", 300, 167, 1'b1);
    px("auto_c511_167", 575, 167, 1'b1);
    px("auto_right_edge", 576, 167, 1'b0);
    px("auto_left_edge", 63, 167, 1'b0);

    // Reset during capture with wr_ptr = 300 (trigger at strobe 128, +299 more)
    trig_level = 8'd128;
    cnt_h = 10'd10; cnt_v = 10'd0;
    for (int i = 0; i < 428; i++) begin
      sample_en = 1'b1;
      sample_data = 8'(i % 256);
      step();
    end
    sample_en = 1'b0;
    chk("mid_busy", {31'd0, capture_busy}, 32'd1);
    px("mid_display", 64, 167, 1'b1);
    rst = 1'b1;
    step();
    chk("mid_rst_wave", {31'd0, vga_wave}, 32'd0);
    chk("mid_rst_busy", {31'd0, capture_busy}, 32'd1);
    chk("mid_rst_auto", {31'd0, trig_auto}, 32'd0);
    rst = 1'b0;
    step();
    feed("recap", 0, 0, 2000, cnt);
    chk("recap_count", 32'(cnt), 32'd640);
    do_swap("recap_swap");
    chk("recap_auto", {31'd0, trig_auto}, 32'd0);
    px("recap_c0_239", 64, 239, 1'b1);
    px("recap_c1_238", 65, 238, 1'b1);
    px("recap_c0_167", 64, 167, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
